// File: rtl/spi_slave_param_if.sv
// Bundle of SPI pins, TX/RX handshakes and status for spi_slave_param.
// The slave modport is the peripheral's view; master is the fabric/host view.
interface spi_slave_param_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
);
    // SPI pins
    logic              spi_sclk;
    logic              spi_cs_n;
    logic              spi_mosi;
    logic              spi_miso;
    logic              spi_miso_oe;
    // per-transaction mode select
    logic              cpol;
    logic              cpha;
    // TX holding-register handshake
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    // RX handshake
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;
    // status
    logic              rx_overrun;
    logic              tx_underrun;
    logic              busy;
    logic [CNT_W-1:0]  word_count;

    modport slave (
        input  spi_sclk, spi_cs_n, spi_mosi, cpol, cpha, tx_data, tx_valid, rx_ready,
        output spi_miso, spi_miso_oe, tx_ready, rx_data, rx_valid, rx_overrun,
               tx_underrun, busy, word_count
    );

    modport master (
        output spi_sclk, spi_cs_n, spi_mosi, cpol, cpha, tx_data, tx_valid, rx_ready,
        input  spi_miso, spi_miso_oe, tx_ready, rx_data, rx_valid, rx_overrun,
               tx_underrun, busy, word_count
    );
endinterface

// File: rtl/spi_slave_param.sv
// Parametrised SPI slave: configurable word width and bit order, all four SPI
// modes latched per chip-select, multi-word bursts, ready/valid TX/RX with
// overrun/underrun pulses. SPI pins are oversampled in the clk domain.
module spi_slave_param #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter bit MSB_FIRST   = 1'b1,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    spi_slave_param_if.slave bus
);

    localparam int               BC_W     = $clog2(DATA_W);
    localparam logic [BC_W-1:0]  LAST_BIT = BC_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic {
        ST_IDLE,
        ST_ACTIVE
    } state_t;

    state_t state;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sclk_d;
    logic                   cs_d;

    logic              cpol_q;
    logic              cpha_q;
    logic [BC_W-1:0]   bit_cnt;
    logic [DATA_W-1:0] tx_shift;
    logic [DATA_W-1:0] rx_shift;
    logic [DATA_W-1:0] hold_data;
    logic              hold_full;

    logic              miso_q;
    logic              miso_oe_q;
    logic [DATA_W-1:0] rx_data_q;
    logic              rx_valid_q;
    logic              rx_overrun_q;
    logic              tx_underrun_q;
    logic              busy_q;
    logic [CNT_W-1:0]  word_count_q;

    // First bit on the wire for a freshly loaded word.
    function automatic logic first_bit(input logic [DATA_W-1:0] w);
        return MSB_FIRST ? w[DATA_W-1] : w[0];
    endfunction

    // Move the next bit into the wire position.
    function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    // Synchronise the asynchronous SPI pins and keep one delayed copy for edge detection.
    // NOTE: the synchroniser flops reset to the idle bus levels (sclk low, cs_n high) so
    // leaving reset never looks like a chip-select or clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.spi_sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.spi_cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.spi_mosi};
            sclk_d    <= sclk_sync[SYNC_STAGES-1];
            cs_d      <= cs_sync[SYNC_STAGES-1];
        end
    end

    logic sclk_s, cs_s, mosi_s;
    logic sclk_rise, sclk_fall, cs_fall, cs_rise;
    logic lead_edge, trail_edge, shift_ev, sample_ev;
    logic word_load;
    logic [DATA_W-1:0] load_word;
    logic [DATA_W-1:0] rx_next;
    logic [DATA_W-1:0] tx_next;

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign cs_fall   = ~cs_s & cs_d;
    assign cs_rise   = cs_s & ~cs_d;

    // Leading edge leaves the CPOL idle level, trailing edge returns to it.
    assign lead_edge  = cpol_q ? sclk_fall : sclk_rise;
    assign trail_edge = cpol_q ? sclk_rise : sclk_fall;
    assign shift_ev   = cpha_q ? lead_edge : trail_edge;
    assign sample_ev  = cpha_q ? trail_edge : lead_edge;

    // A word load happens at CS fall in cpha=0, or on a shift edge at a word boundary.
    assign word_load = ((state == ST_IDLE) && cs_fall && !bus.cpha) ||
                       ((state == ST_ACTIVE) && !cs_rise && shift_ev && (bit_cnt == '0));
    assign load_word = hold_full ? hold_data : '0;
    assign tx_next   = advance(tx_shift);
    assign rx_next   = MSB_FIRST ? {rx_shift[DATA_W-2:0], mosi_s}
                                 : {mosi_s, rx_shift[DATA_W-1:1]};

    // Transaction FSM, shift registers, TX holding register and RX handshake.
    // NOTE: several assignments below may target the same flop in one cycle; with
    // non-blocking assignments the last one written wins, which encodes priority
    // (e.g. a completing word beats the rx_valid clear, a host write beats the load's empty).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            cpol_q        <= 1'b0;
            cpha_q        <= 1'b0;
            bit_cnt       <= '0;
            tx_shift      <= '0;
            rx_shift      <= '0;
            hold_data     <= '0;
            hold_full     <= 1'b0;
            miso_q        <= 1'b0;
            miso_oe_q     <= 1'b0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            rx_overrun_q  <= 1'b0;
            tx_underrun_q <= 1'b0;
            busy_q        <= 1'b0;
            word_count_q  <= '0;
        end else begin
            rx_overrun_q  <= 1'b0;
            tx_underrun_q <= 1'b0;

            if (rx_valid_q && bus.rx_ready) begin
                rx_valid_q <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (cs_fall) begin
                        state        <= ST_ACTIVE;
                        cpol_q       <= bus.cpol;
                        cpha_q       <= bus.cpha;
                        bit_cnt      <= '0;
                        word_count_q <= '0;
                        busy_q       <= 1'b1;
                        miso_oe_q    <= 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    if (cs_rise) begin
                        state     <= ST_IDLE;
                        busy_q    <= 1'b0;
                        miso_oe_q <= 1'b0;
                        miso_q    <= 1'b0;
                        bit_cnt   <= '0;
                    end else if (shift_ev) begin
                        if (bit_cnt != '0) begin
                            tx_shift <= tx_next;
                            miso_q   <= first_bit(tx_next);
                        end
                    end else if (sample_ev) begin
                        rx_shift <= rx_next;
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt    <= '0;
                            rx_data_q  <= rx_next;
                            rx_valid_q <= 1'b1;
                            if (rx_valid_q && !bus.rx_ready) begin
                                rx_overrun_q <= 1'b1;
                            end
                            if (word_count_q != CNT_MAX) begin
                                word_count_q <= word_count_q + CNT_W'(1);
                            end
                        end else begin
                            bit_cnt <= bit_cnt + BC_W'(1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (word_load) begin
                tx_shift <= load_word;
                miso_q   <= first_bit(load_word);
                if (hold_full) begin
                    hold_full <= 1'b0;
                end else begin
                    tx_underrun_q <= 1'b1;
                end
            end

            if (bus.tx_valid && !hold_full) begin
                hold_data <= bus.tx_data;
                hold_full <= 1'b1;
            end
        end
    end

    assign bus.spi_miso    = miso_q;
    assign bus.spi_miso_oe = miso_oe_q;
    assign bus.tx_ready    = ~hold_full;
    assign bus.rx_data     = rx_data_q;
    assign bus.rx_valid    = rx_valid_q;
    assign bus.rx_overrun  = rx_overrun_q;
    assign bus.tx_underrun = tx_underrun_q;
    assign bus.busy        = busy_q;
    assign bus.word_count  = word_count_q;

endmodule
